// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state encoding for uart_rx and uart_tx.
package uart_pkg;

  localparam int unsigned CLK_PER_BIT = 434;
  localparam int unsigned CLK_CNT_W   = 9;
  localparam int unsigned BIT_IDX_W   = 3;
  localparam int unsigned DATA_W      = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    CLEANUP   = 3'd4
  } uart_state_e;

  // Terminal value of a counter that runs 0..clks-1.
  function automatic logic [CLK_CNT_W-1:0] cnt_last(input int unsigned clks);
    return CLK_CNT_W'(clks - 1);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, idle-high line; tx_start ignored while busy.
module uart_tx import uart_pkg::*; #(
  parameter int unsigned CLK_PER_BIT = uart_pkg::CLK_PER_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam logic [CLK_CNT_W-1:0] BIT_LAST = cnt_last(CLK_PER_BIT);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(DATA_W - 1);

  uart_state_e              state;
  logic [CLK_CNT_W-1:0]     clk_count;
  logic [BIT_IDX_W-1:0]     bit_index;
  logic [DATA_W-1:0]        data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clk_count <= '0;
      bit_index <= '0;
      data_q    <= '0;
      tx_out    <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_out    <= 1'b1;
          clk_count <= '0;
          bit_index <= '0;
          if (tx_start) begin
            data_q  <= tx_data;
            tx_busy <= 1'b1;
            tx_out  <= 1'b0;
            state   <= START_BIT;
          end
        end
        START_BIT: begin
          if (clk_count == BIT_LAST) begin
            clk_count <= '0;
            tx_out    <= data_q[0];
            state     <= DATA_BITS;
          end else begin
            clk_count <= clk_count + CLK_CNT_W'(1);
          end
        end
        DATA_BITS: begin
          if (clk_count == BIT_LAST) begin
            clk_count <= '0;
            if (bit_index == IDX_LAST) begin
              bit_index <= '0;
              tx_out    <= 1'b1;
              state     <= STOP_BIT;
            end else begin
              bit_index <= bit_index + BIT_IDX_W'(1);
              tx_out    <= data_q[bit_index + BIT_IDX_W'(1)];
            end
          end else begin
            clk_count <= clk_count + CLK_CNT_W'(1);
          end
        end
        STOP_BIT: begin
          if (clk_count == BIT_LAST) begin
            clk_count <= '0;
            tx_done   <= 1'b1;
            state     <= CLEANUP;
          end else begin
            clk_count <= clk_count + CLK_CNT_W'(1);
          end
        end
        CLEANUP: begin
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state     <= IDLE;
          clk_count <= '0;
          bit_index <= '0;
          tx_out    <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, framing-error pulse and debug taps.
module uart_rx import uart_pkg::*; #(
  parameter int unsigned CLK_PER_BIT = uart_pkg::CLK_PER_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_busy,
  output logic              frame_err,
  output logic [2:0]        debug_state,
  output logic [4:0]        debug_bit_cnt,
  output logic [8:0]        debug_clk_cnt
);

  localparam logic [CLK_CNT_W-1:0] HALF_LAST = cnt_last(CLK_PER_BIT / 2);
  localparam logic [CLK_CNT_W-1:0] BIT_LAST  = cnt_last(CLK_PER_BIT);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST  = BIT_IDX_W'(DATA_W - 1);

  logic                 rx_s;
  uart_state_e          state;
  logic [CLK_CNT_W-1:0] clk_count;
  logic [BIT_IDX_W-1:0] bit_index;
  logic [DATA_W-1:0]    shift_byte;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uart_rx_in),
    .q     (rx_s)
  );

  // Receive FSM; every output is a flop so pulses are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clk_count  <= '0;
      bit_index  <= '0;
      shift_byte <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          clk_count <= '0;
          bit_index <= '0;
          rx_busy   <= 1'b0;
          if (!rx_s) begin
            rx_busy <= 1'b1;
            state   <= START_BIT;
          end
        end
        START_BIT: begin
          // Re-check the line at mid start bit to reject short glitches.
          if (clk_count == HALF_LAST) begin
            clk_count <= '0;
            if (!rx_s) begin
              state <= DATA_BITS;
            end else begin
              rx_busy <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            clk_count <= clk_count + CLK_CNT_W'(1);
          end
        end
        DATA_BITS: begin
          if (clk_count == BIT_LAST) begin
            clk_count             <= '0;
            shift_byte[bit_index] <= rx_s;
            if (bit_index == IDX_LAST) begin
              bit_index <= '0;
              state     <= STOP_BIT;
            end else begin
              bit_index <= bit_index + BIT_IDX_W'(1);
            end
          end else begin
            clk_count <= clk_count + CLK_CNT_W'(1);
          end
        end
        STOP_BIT: begin
          if (clk_count == BIT_LAST) begin
            clk_count <= '0;
            if (rx_s) begin
              rx_data  <= shift_byte;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= CLEANUP;
          end else begin
            clk_count <= clk_count + CLK_CNT_W'(1);
          end
        end
        CLEANUP: begin
          // A held-low line (break) parks here instead of starting a new frame.
          if (rx_s) begin
            rx_busy <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          clk_count <= '0;
          bit_index <= '0;
          rx_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign debug_state   = state;
  assign debug_bit_cnt = 5'(bit_index);
  assign debug_clk_cnt = clk_count;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, corner sequences, tx loopback.
module tb_uart_rx;

  localparam int unsigned CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       bb_line;
  logic       use_tx;
  logic       serial;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic [2:0] debug_state;
  logic [4:0] debug_bit_cnt;
  logic [8:0] debug_clk_cnt;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int last_valid_cyc = 0;
  int fall_cyc = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;
  vec_t vecs[8];

  assign serial = use_tx ? tx_out : bb_line;

  uart_tx #(.CLK_PER_BIT(CPB)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_out   (tx_out),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  uart_rx #(.CLK_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rx_in    (serial),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_busy       (rx_busy),
    .frame_err     (frame_err),
    .debug_state   (debug_state),
    .debug_bit_cnt (debug_bit_cnt),
    .debug_clk_cnt (debug_clk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Scoreboard: every rx_valid must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid || frame_err) chk("valid_ferr_exclusive", int'(rx_valid && frame_err), 0);
      if (frame_err) ferr_cnt++;
      if (rx_valid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else chk("sb_rx_data", int'(rx_data), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    bb_line = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Called at a negedge; leaves the line HIGH afterwards only if release is set.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic release_line);
    bb_line  = 1'b0;
    fall_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    if (release_line) bb_line = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_data"},   int'(rx_data), 0);
    chk({tag, "_rx_valid"},  int'(rx_valid), 0);
    chk({tag, "_frame_err"}, int'(frame_err), 0);
    chk({tag, "_rx_busy"},   int'(rx_busy), 0);
    chk({tag, "_state"},     int'(debug_state), 0);
    chk({tag, "_bit_cnt"},   int'(debug_bit_cnt), 0);
    chk({tag, "_clk_cnt"},   int'(debug_clk_cnt), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, f0, dlt, n;
    logic [7:0] d0;

    vecs[0] = '{8'h55, 1'b1, 8'h55, 1, 0};
    vecs[1] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    vecs[2] = '{8'h3C, 1'b1, 8'h3C, 1, 0};
    vecs[3] = '{8'h81, 1'b0, 8'h3C, 0, 1};
    vecs[4] = '{8'h00, 1'b1, 8'h00, 1, 0};
    vecs[5] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    vecs[6] = '{8'hC3, 1'b0, 8'hFF, 0, 1};
    vecs[7] = '{8'h7E, 1'b1, 8'h7E, 1, 0};

    bb_line = 1'b1; use_tx = 1'b0; tx_start = 1'b0; tx_data = 8'h00; rst_n = 1'b0;
    idle(5);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    idle(4);
    check_reset_outputs("post_reset");

    // Single 0x55 frame with latency window around 9.5 bit times + sync.
    v0 = valid_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b1);
    idle(CPB);
    dlt = last_valid_cyc - fall_cyc;
    chk("lat_valid_cnt", valid_cnt - v0, 1);
    chk("lat_ferr_cnt", ferr_cnt - f0, 0);
    chk("lat_window", int'(dlt >= int'(CPB/2 + 9*CPB) && dlt <= int'(CPB/2 + 9*CPB + 4)), 1);

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      v0 = valid_cnt; f0 = ferr_cnt;
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, 1'b1);
      idle(2 * CPB);
      chk($sformatf("vec%0d_valid", i), valid_cnt - v0, vecs[i].exp_valid);
      chk($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_rx_data", i), int'(rx_data), int'(vecs[i].exp_data));
      chk($sformatf("vec%0d_busy", i), int'(rx_busy), 0);
    end

    // Back-to-back frames with no idle gap.
    v0 = valid_cnt;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_frame(8'hA5, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(2 * CPB);
    chk("b2b_valid_cnt", valid_cnt - v0, 2);
    chk("b2b_rx_data", int'(rx_data), 8'h3C);
    chk("b2b_queue_empty", exp_q.size(), 0);

    // Short LOW glitch: false start, back to IDLE silently.
    v0 = valid_cnt; f0 = ferr_cnt; d0 = rx_data;
    bb_line = 1'b0;
    idle(CPB / 4);
    bb_line = 1'b1;
    idle(2);
    chk("glitch_busy_during", int'(rx_busy), 1);
    idle(CPB);
    chk("glitch_state", int'(debug_state), 0);
    chk("glitch_busy_after", int'(rx_busy), 0);
    chk("glitch_valid", valid_cnt - v0, 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    chk("glitch_rx_data", int'(rx_data), int'(d0));

    // Bad stop followed by a long break.
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(CPB);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h81, 1'b0, 1'b0);
    idle(20 * CPB);
    chk("break_ferr", ferr_cnt - f0, 1);
    chk("break_valid", valid_cnt - v0, 0);
    chk("break_rx_data", int'(rx_data), 8'h3C);
    chk("break_busy", int'(rx_busy), 1);
    chk("break_state", int'(debug_state), 4);
    bb_line = 1'b1;
    idle(CPB);
    chk("break_end_busy", int'(rx_busy), 0);
    chk("break_end_state", int'(debug_state), 0);
    chk("break_end_ferr", ferr_cnt - f0, 1);

    // Reset in the middle of data bit 3 of 0xF0.
    v0 = valid_cnt; f0 = ferr_cnt;
    bb_line = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    bb_line = 1'b0;
    idle(CPB / 2);
    chk("pre_rst_state", int'(debug_state), 2);
    chk("pre_rst_bit_cnt", int'(debug_bit_cnt), 3);
    rst_n = 1'b0;
    idle(1);
    check_reset_outputs("mid_rst");
    bb_line = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(12 * CPB);
    chk("post_rst_valid", valid_cnt - v0, 0);
    chk("post_rst_ferr", ferr_cnt - f0, 0);
    chk("post_rst_state", int'(debug_state), 0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 1'b1);
    idle(CPB);
    chk("post_rst_frame_valid", valid_cnt - v0, 1);
    chk("post_rst_frame_data", int'(rx_data), 8'h0F);

    // Loopback through uart_tx for every byte value.
    use_tx = 1'b1;
    idle(2);
    v0 = valid_cnt; f0 = ferr_cnt;
    for (int b = 0; b < 256; b++) begin
      exp_q.push_back(8'(b));
      tx_data  = 8'(b);
      tx_start = 1'b1;
      idle(1);
      tx_start = 1'b0;
      n = 0;
      while (!tx_done && n < 12 * int'(CPB)) begin idle(1); n++; end
      if (n >= 12 * int'(CPB)) chk("tx_done_timeout", n, 0);
      n = 0;
      while (tx_busy && n < 8) begin idle(1); n++; end
    end
    idle(4 * CPB);
    chk("loop_valid_cnt", valid_cnt - v0, 256);
    chk("loop_ferr_cnt", ferr_cnt - f0, 0);
    chk("loop_queue_empty", exp_q.size(), 0);
    chk("loop_last_data", int'(rx_data), 8'hFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
